// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: forwarding-select encoding
// and the default register-address width.
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    FWD_GPR   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle for hazard_scoreboard: master = pipeline, slave = scoreboard.
// Defining HAZARD_PERF_CNT_EN adds the o_stall_cycles / o_fwd_events counter outputs.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
);

  logic                  i_idex_valid;
  logic [REG_ADDR_W-1:0] i_idex_rs1_addr;
  logic [REG_ADDR_W-1:0] i_idex_rs2_addr;
  logic                  i_idex_uses_rs1;
  logic                  i_idex_uses_rs2;
  logic [REG_ADDR_W-1:0] i_idex_rd_addr;
  logic                  i_idex_write;
  logic                  i_idex_is_load;
  logic                  i_exmem_write;
  logic                  i_exmem_read;
  logic [REG_ADDR_W-1:0] i_exmem_rd_addr;
  logic                  i_memwb_write;
  logic [REG_ADDR_W-1:0] i_memwb_addr;
  logic                  i_wb_write;
  logic [REG_ADDR_W-1:0] i_wb_addr;
  logic                  i_flush;
  logic [1:0]            o_muxA_select;
  logic [1:0]            o_muxB_select;
  logic                  o_pipeline_stall;
  logic                  o_stall_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      o_stall_cycles;
  logic [CNT_W-1:0]      o_fwd_events;
`endif

  modport master (
    output i_idex_valid, i_idex_rs1_addr, i_idex_rs2_addr, i_idex_uses_rs1, i_idex_uses_rs2,
           i_idex_rd_addr, i_idex_write, i_idex_is_load, i_exmem_write, i_exmem_read,
           i_exmem_rd_addr, i_memwb_write, i_memwb_addr, i_wb_write, i_wb_addr, i_flush,
    input  o_muxA_select, o_muxB_select, o_pipeline_stall, o_stall_timeout
`ifdef HAZARD_PERF_CNT_EN
    , input o_stall_cycles, o_fwd_events
`endif
  );

  modport slave (
    input  i_idex_valid, i_idex_rs1_addr, i_idex_rs2_addr, i_idex_uses_rs1, i_idex_uses_rs2,
           i_idex_rd_addr, i_idex_write, i_idex_is_load, i_exmem_write, i_exmem_read,
           i_exmem_rd_addr, i_memwb_write, i_memwb_addr, i_wb_write, i_wb_addr, i_flush,
    output o_muxA_select, o_muxB_select, o_pipeline_stall, o_stall_timeout
`ifdef HAZARD_PERF_CNT_EN
    , output o_stall_cycles, o_fwd_events
`endif
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding priority selector: youngest forwardable producer wins
// (EX/MEM ALU result, then MEM/WB, then WB, else register file).
module hazard_fwd_sel
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  uses_i,
  input  logic [REG_ADDR_W-1:0] src_addr_i,
  input  logic                  exmem_write_i,
  input  logic                  exmem_read_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr_i,
  input  logic                  memwb_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_addr_i,
  input  logic                  wb_write_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  output fwd_sel_e              sel_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives sel_o and no latch is inferred.
    sel_o = FWD_GPR;
    if (uses_i) begin
      // A load sitting in EX/MEM has no data yet; the scoreboard stall covers that case.
      if (exmem_write_i && !exmem_read_i && exmem_rd_addr_i == src_addr_i) begin
        sel_o = FWD_EXMEM;
      end else if (memwb_write_i && memwb_addr_i == src_addr_i) begin
        sel_o = FWD_MEMWB;
      end else if (wb_write_i && wb_addr_i == src_addr_i) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard unit with per-register load scoreboard, operand forwarding and stall watchdog.
// Defining HAZARD_PERF_CNT_EN adds saturating stall-cycle and forward-event counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STALL_MAX  = 15,
  parameter int STALL_W    = 4
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W    = 16
`endif
) (
  input logic               i_clk,
  input logic               i_rst,
  hazard_scoreboard_if.slave bus
);

  localparam int               NUM_REGS  = 2 ** REG_ADDR_W;
  localparam logic [2:0]       LAT_INIT  = 3'(MEM_LAT);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [2:0]          cnt_q [NUM_REGS];
  logic [2:0]          cnt_d [NUM_REGS];
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                timeout_q, timeout_d;
  logic                stall, issue;
  fwd_sel_e            sel_a, sel_b;

  assign stall = bus.i_idex_valid && !bus.i_flush &&
                 ((bus.i_idex_uses_rs1 && busy_q[bus.i_idex_rs1_addr]) ||
                  (bus.i_idex_uses_rs2 && busy_q[bus.i_idex_rs2_addr]));
  assign issue = bus.i_idex_valid && !bus.i_flush && !stall;

  // Issue overrides countdown for its rd; every other busy entry ticks down, even while stalled.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue && bus.i_idex_write && int'(bus.i_idex_rd_addr) == r) begin
        busy_d[r] = bus.i_idex_is_load;
        cnt_d[r]  = bus.i_idex_is_load ? LAT_INIT : 3'd0;
      end else if (busy_q[r]) begin
        cnt_d[r] = cnt_q[r] - 3'd1;
        if (cnt_q[r] == 3'd1) busy_d[r] = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d = '0;
    if (stall) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + STALL_W'(1);
    end
    timeout_d = timeout_q || (stall_cnt_d >= STALL_LIM);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q      <= '0;
      cnt_q       <= '{default: '0};
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .uses_i          (bus.i_idex_uses_rs1),
    .src_addr_i      (bus.i_idex_rs1_addr),
    .exmem_write_i   (bus.i_exmem_write),
    .exmem_read_i    (bus.i_exmem_read),
    .exmem_rd_addr_i (bus.i_exmem_rd_addr),
    .memwb_write_i   (bus.i_memwb_write),
    .memwb_addr_i    (bus.i_memwb_addr),
    .wb_write_i      (bus.i_wb_write),
    .wb_addr_i       (bus.i_wb_addr),
    .sel_o           (sel_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .uses_i          (bus.i_idex_uses_rs2),
    .src_addr_i      (bus.i_idex_rs2_addr),
    .exmem_write_i   (bus.i_exmem_write),
    .exmem_read_i    (bus.i_exmem_read),
    .exmem_rd_addr_i (bus.i_exmem_rd_addr),
    .memwb_write_i   (bus.i_memwb_write),
    .memwb_addr_i    (bus.i_memwb_addr),
    .wb_write_i      (bus.i_wb_write),
    .wb_addr_i       (bus.i_wb_addr),
    .sel_o           (sel_b)
  );

  assign bus.o_muxA_select    = sel_a;
  assign bus.o_muxB_select    = sel_b;
  assign bus.o_pipeline_stall = stall;
  assign bus.o_stall_timeout  = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, fwd_events_q;
  logic             fwd_event;

  assign fwd_event = bus.i_idex_valid && !stall && (sel_a != FWD_GPR || sel_b != FWD_GPR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      if (stall && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (fwd_event && fwd_events_q != '1) fwd_events_q <= fwd_events_q + CNT_W'(1);
    end
  end

  assign bus.o_stall_cycles = stall_cycles_q;
  assign bus.o_fwd_events   = fwd_events_q;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the 2-bit, single-stall RAW hazard detector.
- Adds per-register load scoreboard with countdown for variable memory latency (MEM_LAT), generic register-file size, decoupled operand-use flags, flush handling and a stall watchdog.
- Sits beside the ID/EX pipeline register. Drives the EX operand forwarding muxes and the front-end stall.

Parameters:
- REG_ADDR_W, 2, register address width; NUM_REGS = 2**REG_ADDR_W.
- MEM_LAT, 1, cycles from load leaving ID/EX until its data is forwardable from MEM/WB; range 1..7.
- STALL_MAX, 15, consecutive stall cycles that trip the watchdog; range 1..2**STALL_W-1.
- STALL_W, 4, width of the consecutive-stall counter.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_idex_valid  in  1  ID/EX holds a real instruction.
- i_idex_rs1_addr  in  REG_ADDR_W  EX source 1 address.
- i_idex_rs2_addr  in  REG_ADDR_W  EX source 2 address.
- i_idex_uses_rs1  in  1  instruction reads rs1.
- i_idex_uses_rs2  in  1  instruction reads rs2.
- i_idex_rd_addr  in  REG_ADDR_W  destination address.
- i_idex_write  in  1  instruction writes rd.
- i_idex_is_load  in  1  instruction is a load.
- i_exmem_write  in  1  EX/MEM writes its rd.
- i_exmem_read  in  1  EX/MEM is a load.
- i_exmem_rd_addr  in  REG_ADDR_W  EX/MEM destination.
- i_memwb_write  in  1  MEM/WB writes.
- i_memwb_addr  in  REG_ADDR_W  MEM/WB destination.
- i_wb_write  in  1  WB-stage write.
- i_wb_addr  in  REG_ADDR_W  WB destination.
- i_flush  in  1  kill ID/EX instruction this cycle.
- o_muxA_select  out  2  forward select for operand A: 00 GPR, 01 EX/MEM, 10 MEM/WB, 11 WB.
- o_muxB_select  out  2  forward select for operand B, same encoding.
- o_pipeline_stall  out  1  hold PC, IF/ID and ID/EX; insert bubble into EX/MEM.
- o_stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (i_rst high, asynchronous): all scoreboard busy bits 0, countdowns 0, stall counter 0, o_stall_timeout 0. Combinational outputs then evaluate to 00/00/0 while the scoreboard is empty.
- Scoreboard state: per register, busy[r] and cnt[r] (3 bits).
- Issue: define issue = i_idex_valid && !i_flush && !o_pipeline_stall.
  - issue && i_idex_write && i_idex_is_load: busy[rd]=1, cnt[rd]=MEM_LAT.
  - issue && i_idex_write && !i_idex_is_load: busy[rd]=0 (WAW, the newer ALU result wins).
- Countdown: every cycle, including stall cycles, each busy entry not written by issue that cycle decrements cnt. When cnt reaches 0, busy clears in the same edge. Issue write has priority over decrement for the same register.
- Stall (combinational): o_pipeline_stall = i_idex_valid && !i_flush && ((uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2])).
  - With MEM_LAT=1, a load followed by an immediate consumer gives exactly 1 stall cycle, then forward from MEM/WB.
- Forwarding (combinational, per operand, only when the operand's uses flag is set):
  - 01 if i_exmem_write && !i_exmem_read && address match;
  - else 10 if i_memwb_write && address match;
  - else 11 if i_wb_write && address match;
  - else 00.
  - While o_pipeline_stall=1 the selects are don't-care; they are still driven per the rules above.
- Watchdog: stall counter increments (saturating) on each stall cycle and clears on any non-stall cycle. Reaching STALL_MAX sets o_stall_timeout, which holds until reset.
- i_flush: suppresses stall and issue for that cycle. Countdowns continue, because loads already in MEM still return.
- Reset mid-countdown: all entries clear immediately.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined: adds outputs o_stall_cycles (CNT_W) and o_fwd_events (CNT_W).
  - o_stall_cycles counts cycles with o_pipeline_stall=1.
  - o_fwd_events counts non-stall valid cycles in which either select is non-zero.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - forwarding-select constants FWD_GPR=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WB=2'b11;
  - REG_ADDR_W default.
- One natural sub-module, hazard_fwd_sel: combinational priority selector, instantiated twice (operands A and B).

Test Plan:
- MEM_LAT=1: load r1 issued, next cycle ADD reads rs1=r1 -> stall=1 for exactly 1 cycle, then muxA=10, stall=0.
- MEM_LAT=3: load r2, then consumer on rs2=r2 -> stall high 3 cycles, muxB=10 on release. Consumer with uses_rs2=0 -> no stall.
- Load r1 then ALU write r1 issued before any consumer -> busy[r1] cleared; consumer sees muxA=01, no stall.
- EX/MEM, MEM/WB and WB all write r3; consumer reads r3 on both operands -> muxA=muxB=01. With EX/MEM not writing -> 10. Only WB writing -> 11.
- Hold a consumer against busy by forcing STALL_MAX=4 (i_idex_valid held, load repeatedly re-armed by test hook or MEM_LAT=7) -> o_stall_timeout=1 after the 4th stall cycle, sticky. i_rst mid-countdown -> stall=0 immediately.
- i_flush=1 with dependent consumer in ID/EX -> stall=0, no scoreboard update. With HAZARD_PERF_CNT_EN, o_stall_cycles equals the number of stall cycles in this test.
